// File: rtl/polling_arbiter_pkg.sv
// Shared definitions for the polling arbiter: FSM encoding, register map,
// CRC-8 parameters and the bytewise CRC helper.
package polling_arbiter_pkg;

    localparam int         ID_W          = 4;
    localparam logic [7:0] CRC_POLY      = 8'h07;
    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_SLOT_FIRST = 4'd1;
    localparam int         CTRL_EN_BIT        = 0;
    localparam int         CTRL_ALARM_CLR_BIT = 1;
    localparam int         CTRL_STATS_CLR_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_RX_DATA  = 3'd2,
        ST_RX_CRC   = 3'd3,
        ST_CHECK    = 3'd4,
        ST_RECOVERY = 3'd5
    } state_t;

    // CRC-8, init 0x00, MSB first, no reflection, over a single byte
    function automatic logic [7:0] crc8(input logic [7:0] data);
        logic [7:0] c;
        c = data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/polling_arbiter_if.sv
// Register bus between the host and the polling arbiter.
interface polling_arbiter_if;

    logic        chip_select;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chip_select, read, write, address, writedata,
        input  readdata
    );

    modport slave (
        input  chip_select, read, write, address, writedata,
        output readdata
    );

endinterface

// File: rtl/polling_arbiter_crc8_check.sv
// Combinational check of a received data/CRC pair and alarm-code detection.
module crc8_check
    import polling_arbiter_pkg::*;
#(
    parameter logic [7:0] ALARM_CODE = 8'hFF
) (
    input  logic [7:0] data,
    input  logic [7:0] crc,
    output logic       crc_ok,
    output logic       is_alarm
);

    // Compare the locally computed CRC with the received one
    always_comb begin
        crc_ok   = (crc8(data) == crc);
        is_alarm = (data == ALARM_CODE);
    end

endmodule

// File: rtl/polling_arbiter.sv
// Round-robin sensor poller over a UART link with CRC check, retries and alarm.
// Optional CRC-failure statistics counter enabled by defining POLL_STATS_EN.
module polling_arbiter
    import polling_arbiter_pkg::*;
#(
    parameter int         NUM_SENSORS    = 5,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         MAX_RETRIES    = 3,
    parameter logic [7:0] ALARM_CODE     = 8'hFF
) (
    input  logic                   clock,
    input  logic                   reset,
    polling_arbiter_if.slave       bus,
    output logic [7:0]             tx_data,
    output logic                   tx_wr_en,
    input  logic                   tx_busy,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   rx_rdy_clr,
    output logic [2:0]             state,
    output logic                   alarm
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam int              RW           = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [ID_W-1:0] LAST_ID      = ID_W'(NUM_SENSORS);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]   RETRY_MAX    = RW'(MAX_RETRIES);

    state_t            state_r, state_n;
    logic [TW-1:0]     timer_r;
    logic [ID_W-1:0]   id_r, next_id_s, alarm_id_r;
    logic [RW-1:0]     retry_r;
    logic              enable_r, alarm_r;
    logic [15:0]       err_r, id_mask_s;
    logic [31:0]       slot_r [NUM_SENSORS];
    logic [7:0]        data_r, crc_r, tx_data_r;
    logic              tx_wr_en_r, rx_rdy_clr_r;
    logic [31:0]       readdata_r, rd_mux_s, slot_rd_s;

    logic tx_wr_en_s, rx_rdy_clr_s, cap_data_s, cap_crc_s;
    logic fail_s, crc_fail_s, store_s, recover_s, retry_inc_s, advance_s, set_err_s;
    logic crc_ok_s, is_alarm_s, rx_take_s, timeout_s, ctrl_wr_s, unused_s;

    crc8_check #(.ALARM_CODE(ALARM_CODE)) u_crc (
        .data     (data_r),
        .crc      (crc_r),
        .crc_ok   (crc_ok_s),
        .is_alarm (is_alarm_s)
    );

    // A byte still flagged during our own acknowledge cycle is the one just taken
    assign rx_take_s = rx_rdy && !rx_rdy_clr_r;
    assign timeout_s = (timer_r == TIMEOUT_LAST);
    assign next_id_s = (id_r == LAST_ID) ? ID_W'(1) : id_r + ID_W'(1);
    assign id_mask_s = 16'd1 << (id_r - ID_W'(1));
    assign ctrl_wr_s = bus.chip_select && bus.write && (bus.address == ADDR_CTRL);
    assign unused_s  = ^{bus.writedata[31:2], crc_fail_s};

    // Next-state and transaction control decode
    always_comb begin
        state_n      = state_r;
        tx_wr_en_s   = 1'b0;
        rx_rdy_clr_s = 1'b0;
        cap_data_s   = 1'b0;
        cap_crc_s    = 1'b0;
        fail_s       = 1'b0;
        crc_fail_s   = 1'b0;
        store_s      = 1'b0;
        recover_s    = 1'b0;
        retry_inc_s  = 1'b0;
        advance_s    = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_r) state_n = ST_SEND;
                else          state_n = ST_IDLE;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_wr_en_s = 1'b1;
                    state_n    = ST_RX_DATA;
                end else begin
                    state_n    = ST_SEND;
                end
            end
            ST_RX_DATA: begin
                if (rx_take_s) begin
                    cap_data_s   = 1'b1;
                    rx_rdy_clr_s = 1'b1;
                    state_n      = ST_RX_CRC;
                end else if (timeout_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_n = ST_RX_DATA;
                end
            end
            ST_RX_CRC: begin
                if (rx_take_s) begin
                    cap_crc_s    = 1'b1;
                    rx_rdy_clr_s = 1'b1;
                    state_n      = ST_CHECK;
                end else if (timeout_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_n = ST_RX_CRC;
                end
            end
            ST_CHECK: begin
                if (!crc_ok_s) begin
                    fail_s     = 1'b1;
                    crc_fail_s = 1'b1;
                end else if (is_alarm_s) begin
                    state_n = ST_RECOVERY;
                end else begin
                    store_s   = 1'b1;
                    advance_s = 1'b1;
                    state_n   = enable_r ? ST_SEND : ST_IDLE;
                end
            end
            ST_RECOVERY: begin
                recover_s = 1'b1;
                state_n   = ST_SEND;
            end
            default: state_n = ST_IDLE;
        endcase
        if (fail_s) begin
            if (retry_r < RETRY_MAX) begin
                retry_inc_s = 1'b1;
            end else begin
                set_err_s = 1'b1;
                advance_s = 1'b1;
            end
            state_n = enable_r ? ST_SEND : ST_IDLE;
        end else begin
            retry_inc_s = 1'b0;
        end
    end

    // State register and per-state timeout counter (restarts on every state change)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= TW'(0);
        end else begin
            state_r <= state_n;
            if (state_n != state_r) timer_r <= TW'(0);
            else                    timer_r <= timer_r + TW'(1);
        end
    end

    // Transaction datapath: UART strobes, captured bytes, ID/retry, slots, error bits
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_en_r   <= 1'b0;
            rx_rdy_clr_r <= 1'b0;
            tx_data_r    <= 8'h00;
            data_r       <= 8'h00;
            crc_r        <= 8'h00;
            id_r         <= ID_W'(1);
            retry_r      <= RW'(0);
            alarm_id_r   <= ID_W'(0);
            err_r        <= 16'h0000;
            for (int i = 0; i < NUM_SENSORS; i++) slot_r[i] <= 32'h0;
        end else begin
            tx_wr_en_r   <= tx_wr_en_s;
            rx_rdy_clr_r <= rx_rdy_clr_s;
            if (tx_wr_en_s) tx_data_r <= {4'h0, id_r};
            if (cap_data_s) data_r <= rx_data;
            if (cap_crc_s)  crc_r  <= rx_data;
            if (recover_s) begin
                alarm_id_r <= id_r;
                id_r       <= ID_W'(1);
                retry_r    <= RW'(0);
            end else if (advance_s) begin
                id_r    <= next_id_s;
                retry_r <= RW'(0);
            end else if (retry_inc_s) begin
                retry_r <= retry_r + RW'(1);
            end
            if (set_err_s)    err_r <= err_r | id_mask_s;
            else if (store_s) err_r <= err_r & ~id_mask_s;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (store_s && (id_r == ID_W'(i + 1)))
                    slot_r[i] <= {8'h00, 4'h0, id_r, crc_r, data_r};
            end
        end
    end

    // Host-visible control bits; a same-cycle recovery beats an alarm clear
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_r   <= 1'b0;
            alarm_r    <= 1'b0;
            readdata_r <= 32'h0;
        end else begin
            if (ctrl_wr_s) enable_r <= bus.writedata[CTRL_EN_BIT];
            if (recover_s)
                alarm_r <= 1'b1;
            else if (ctrl_wr_s && bus.writedata[CTRL_ALARM_CLR_BIT])
                alarm_r <= 1'b0;
            if (bus.chip_select && bus.read) readdata_r <= rd_mux_s;
        end
    end

`ifdef POLL_STATS_EN
    localparam logic [3:0] ADDR_STATS = ID_W'(NUM_SENSORS + 1);
    logic [15:0] crc_fail_cnt_r;

    // Saturating count of CRC mismatches seen in CHECK
    always_ff @(posedge clock) begin
        if (reset)
            crc_fail_cnt_r <= 16'h0;
        else if (ctrl_wr_s && bus.writedata[CTRL_STATS_CLR_BIT])
            crc_fail_cnt_r <= 16'h0;
        else if (crc_fail_s && (crc_fail_cnt_r != 16'hFFFF))
            crc_fail_cnt_r <= crc_fail_cnt_r + 16'd1;
    end
`endif

    // Register read multiplexer
    always_comb begin
        slot_rd_s = 32'h0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            slot_rd_s = (bus.address == (ADDR_SLOT_FIRST + ID_W'(i))) ? slot_r[i] : slot_rd_s;
        end
        if (bus.address == ADDR_CTRL)
            rd_mux_s = {alarm_id_r, alarm_r, enable_r, 10'b0, err_r};
`ifdef POLL_STATS_EN
        else if (bus.address == ADDR_STATS)
            rd_mux_s = {16'h0, crc_fail_cnt_r};
`endif
        else
            rd_mux_s = slot_rd_s;
    end

    assign bus.readdata = readdata_r;
    assign tx_data      = tx_data_r;
    assign tx_wr_en     = tx_wr_en_r;
    assign rx_rdy_clr   = rx_rdy_clr_r;
    assign state        = state_r;
    assign alarm        = alarm_r;

endmodule

// File: tb/tb_polling_arbiter.sv
// Directed self-checking bench for polling_arbiter (2 sensors, 100-cycle timeout).
module tb_polling_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_rdy_clr;
    logic [2:0]  state;
    logic        alarm;

    int errors = 0;
    int checks = 0;
    int n;
    int pulses;
    logic [31:0] stats_exp;

    polling_arbiter_if bus ();

    polling_arbiter #(
        .NUM_SENSORS    (2),
        .TIMEOUT_CYCLES (100),
        .MAX_RETRIES    (3),
        .ALARM_CODE     (8'hFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .tx_data    (tx_data),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .state      (state),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.chip_select = 1'b1;
        bus.write       = 1'b1;
        bus.address     = a;
        bus.writedata   = d;
        tick();
        bus.chip_select = 1'b0;
        bus.write       = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.chip_select = 1'b1;
        bus.read        = 1'b1;
        bus.address     = a;
        tick();
        bus.chip_select = 1'b0;
        bus.read        = 1'b0;
        check(tag, bus.readdata, exp);
    endtask

    // Present one byte like a UART receiver and drop it once acknowledged
    task automatic rx_byte(input logic [7:0] b);
        int k;
        rx_data = b;
        rx_rdy  = 1'b1;
        k = 0;
        tick();
        while (rx_rdy_clr !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check("rx_ack", {31'd0, rx_rdy_clr}, 32'd1);
        rx_rdy = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (tx_wr_en !== 1'b1 && k < 300);
        check({tag, "_pulse"}, {31'd0, tx_wr_en}, 32'd1);
        check(tag, {24'd0, tx_data}, {24'd0, exp});
    endtask

    initial begin
        reset           = 1'b1;
        bus.chip_select = 1'b0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.address     = 4'd0;
        bus.writedata   = 32'd0;
        tx_busy         = 1'b0;
        rx_data         = 8'h00;
        rx_rdy          = 1'b0;
`ifdef POLL_STATS_EN
        stats_exp = 32'd3;
`else
        stats_exp = 32'd0;
`endif

        // Reset state
        repeat (3) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_tx_wr_en", {31'd0, tx_wr_en}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_disabled", {29'd0, state}, 32'd0);
        read_check("rst_ctrl", 4'd0, 32'd0);

        // Good reply from sensor 1, then sensor 2, then wrap to 1
        bus_write(4'd0, 32'h1);
        wait_tx("tx_id1", 8'h01);
        rx_byte(8'h01);
        rx_byte(8'h07);
        wait_tx("tx_id2", 8'h02);
        read_check("slot1", 4'd1, 32'h0001_0701);
        read_check("addr4_zero", 4'd4, 32'd0);
        read_check("addr15_zero", 4'd15, 32'd0);
        rx_byte(8'h02);
        rx_byte(8'h0E);
        wait_tx("tx_wrap", 8'h01);
        read_check("slot2", 4'd2, 32'h0002_0E02);

        // Four CRC failures on sensor 1: three retries then error bit
        bus_write(4'd0, 32'h5);
        for (int r = 0; r < 3; r++) begin
            rx_byte(8'h01);
            rx_byte(8'h00);
            wait_tx("tx_retry_id1", 8'h01);
        end
        read_check("crc_fail_stats", 4'd3, stats_exp);
        rx_byte(8'h01);
        rx_byte(8'h00);
        wait_tx("tx_after_max", 8'h02);

        // No reply from sensor 2: SEND again 100 cycles after RX_DATA entry
        n = 0;
        do begin
            tick();
            n++;
        end while (state !== 3'd1 && n < 300);
        check("timeout_cycles", n, 32'd100);
        wait_tx("tx_timeout_retry", 8'h02);
        read_check("err_bit0", 4'd0, 32'h0400_0001);
        wait_tx("tx_timeout_retry2", 8'h02);
        wait_tx("tx_timeout_retry3", 8'h02);
        wait_tx("tx_after_timeouts", 8'h01);
        read_check("err_bits01", 4'd0, 32'h0400_0003);

        // Good reply clears err bit0; SEND holds while transmitter busy
        tx_busy = 1'b1;
        rx_byte(8'h01);
        rx_byte(8'h07);
        pulses = 0;
        repeat (6) begin
            tick();
            if (tx_wr_en === 1'b1) pulses++;
        end
        check("busy_no_pulse", pulses, 32'd0);
        check("busy_in_send", {29'd0, state}, 32'd1);
        tx_busy = 1'b0;
        wait_tx("tx_after_busy", 8'h02);

        // Alarm from sensor 2
        rx_byte(8'hFF);
        rx_byte(8'hF3);
        tick();
        check("recovery_state", {29'd0, state}, 32'd5);
        tick();
        check("alarm_set", {31'd0, alarm}, 32'd1);
        wait_tx("tx_after_alarm", 8'h01);
        read_check("alarm_ctrl", 4'd0, 32'h2C00_0002);
        bus_write(4'd0, 32'h3);
        check("alarm_cleared", {31'd0, alarm}, 32'd0);
        read_check("ctrl_after_clear", 4'd0, 32'h2400_0002);

        // Reset in RX_CRC aborts the transaction
        rx_byte(8'h01);
        check("in_rx_crc", {29'd0, state}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", {29'd0, state}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("mid_rst_rx_clr", {31'd0, rx_rdy_clr}, 32'd0);
        check("mid_rst_readdata", bus.readdata, 32'd0);
        read_check("mid_rst_ctrl", 4'd0, 32'd0);
        read_check("mid_rst_slot1", 4'd1, 32'd0);
        read_check("mid_rst_slot2", 4'd2, 32'd0);

        // Disable mid-transaction: finish through CHECK, then IDLE
        bus_write(4'd0, 32'h1);
        wait_tx("tx_reenable", 8'h01);
        bus_write(4'd0, 32'h0);
        rx_byte(8'h03);
        rx_byte(8'h09);
        n = 0;
        pulses = 0;
        do begin
            tick();
            n++;
            if (tx_wr_en === 1'b1) pulses++;
        end while (state !== 3'd0 && n < 20);
        check("disable_idle", {29'd0, state}, 32'd0);
        check("disable_no_send", pulses, 32'd0);
        read_check("disable_slot1", 4'd1, 32'h0001_0903);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/polling_arbiter.md
POLLING_ARBITER -- requirements
Module: polling_arbiter

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 5, number of polled sensors with IDs 1..NUM_SENSORS (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, clock cycles allowed per received byte.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, re-requests allowed per sensor after a timeout or CRC failure.
REQ-004 SHALL have parameter ALARM_CODE, default 8'hFF, data byte that signals an alarm.
REQ-005 SHALL have port clock  in  1  sole clock; all logic is on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports chip_select, read, write  in  1 each  bus strobes.
REQ-008 SHALL have port address  in  4  register select.
REQ-009 SHALL have port writedata  in  32  bus write data; port readdata  out  32  registered bus read data.
REQ-010 SHALL have port tx_data  out  8  request byte; port tx_wr_en  out  1  one-cycle send pulse; port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port rx_data  in  8  received byte; port rx_rdy  in  1  byte valid; port rx_rdy_clr  out  1  one-cycle acknowledge.
REQ-012 SHALL have port state  out  3  current FSM state; port alarm  out  1  sticky alarm flag.

Function
REQ-013 SHALL implement states IDLE, SEND, RX_DATA, RX_CRC, CHECK and RECOVERY.
REQ-014 IDLE SHALL go to SEND when the enable bit (CTRL bit0) is 1.
REQ-015 SEND SHALL wait for tx_busy==0, then pulse tx_wr_en for one cycle with tx_data={4'h0,sensor_id}, then go to RX_DATA.
REQ-016 RX_DATA and RX_CRC SHALL, on rx_rdy, capture rx_data, pulse rx_rdy_clr for one cycle and advance.
REQ-017 A per-byte timeout counter SHALL reset on each state entry; reaching TIMEOUT_CYCLES-1 SHALL be treated as a failure.
REQ-018 CHECK SHALL compute CRC-8 (poly 0x07, init 0x00, no reflection) over the data byte and compare it with the received CRC byte.
REQ-019 A matching CRC with data==ALARM_CODE SHALL go to RECOVERY.
REQ-020 A matching CRC with any other data SHALL store {8'h00, id, crc, data} into the slot for that sensor, clear its error bit, advance the ID and return to SEND (IDLE if enable is 0).
REQ-021 A failure (CRC mismatch or timeout) with retry count < MAX_RETRIES SHALL increment the retry count and return to SEND for the same ID.
REQ-022 A failure with retry count == MAX_RETRIES SHALL set that sensor's error bit and advance the ID.
REQ-023 The sensor ID SHALL wrap from NUM_SENSORS to 1; the retry count SHALL clear on every ID change.
REQ-024 RECOVERY SHALL set alarm, latch the alarm sensor ID, reset the ID to 1 and go to SEND in one cycle.
REQ-025 Clearing enable mid-transaction SHALL let the current transaction finish through CHECK, then go to IDLE.
REQ-026 Register map:
  - address 0 reads {alarm_id[3:0], alarm, enable, 10'b0, err_bits[15:0]};
  - addresses 1..NUM_SENSORS read the sensor slots;
  - any other address reads 0.
REQ-027 readdata SHALL update one cycle after chip_select&&read.
REQ-028 A write to address 0 SHALL set enable=writedata[0]; writedata[1]=1 SHALL clear alarm. If RECOVERY occurs in the same cycle, set wins.

Reset
REQ-029 reset SHALL force state=IDLE, ID=1, retry=0, enable=0, alarm=0, all slots and error bits=0, readdata=0, tx_wr_en=0, rx_rdy_clr=0 and tx_data=0.
REQ-030 reset asserted mid-transaction SHALL abort the transaction with no slot update.

Configuration
REQ-031 With POLL_STATS_EN defined, a 16-bit saturating CRC-failure counter SHALL be readable at address NUM_SENSORS+1 and cleared by writedata[2]=1 to address 0.
REQ-032 Without POLL_STATS_EN, no counter logic SHALL be present and that address SHALL read 0.

Structure
REQ-033 State encodings, register addresses, CRC polynomial and ID width SHALL live in package polling_arbiter_pkg.
REQ-034 The CRC SHALL be a combinational sub-module crc8_check (inputs data and crc; outputs crc_ok and is_alarm).

Verification
REQ-035 Enable with NUM_SENSORS=2; sensor 1 replies 0x01/0x07 -> slot1=0x00010701, next tx_data=0x02.
REQ-036 Sensor 1 replies 0x01/0x00 four times -> four SEND pulses for ID 1, err bit0=1, next tx_data=0x02.
REQ-037 No reply, TIMEOUT_CYCLES=100 -> SEND re-issued 100 cycles after RX_DATA entry, retry count increments.
REQ-038 Reply 0xFF/0xF3 from ID 2 -> alarm=1, alarm_id=2, next tx_data=0x01; write 0x2 to address 0 -> alarm=0.
REQ-039 reset pulsed in RX_CRC -> state=IDLE and all outputs zero next cycle; slots unchanged from 0.
REQ-040 POLL_STATS_EN with three CRC failures -> address NUM_SENSORS+1 reads 3.
